// File: rtl/fec_hv_dac_pkg.sv
// rtl/fec_hv_dac_pkg.sv - shared types and constants for the HV DAC serial writer
package fec_hv_dac_pkg;

    localparam int HV_DAC_FRAME_W = 16;
    localparam int HV_DAC_CHIPS   = 4;
    localparam int HV_DAC_CODE_W  = 12;
    localparam int HV_DAC_CH_W    = 3;
    localparam int HV_DAC_CHIP_W  = $clog2(HV_DAC_CHIPS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_LDAC,
        ST_GAP
    } hv_dac_state_e;

    // Leading zero is the DAC's write-to-input-register command bit.
    function automatic logic [HV_DAC_FRAME_W-1:0] hv_dac_frame(
        input logic [HV_DAC_CH_W-1:0]   ch,
        input logic [HV_DAC_CODE_W-1:0] code
    );
        return {1'b0, ch, code};
    endfunction

endpackage

// File: rtl/fec_tick_gen.sv
// rtl/fec_tick_gen.sv - strobe every HALF_PER enabled cycles, restartable by clr
module fec_tick_gen #(
    parameter int HALF_PER = 3
) (
    input  logic dtc_clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int            CW   = $clog2(HALF_PER + 1);
    localparam logic [CW-1:0] LAST = CW'(HALF_PER - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr || tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge dtc_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fec_hv_dac_spi.sv
// rtl/fec_hv_dac_spi.sv - serialises one 16-bit write to a selected HV DAC chip
module fec_hv_dac_spi
    import fec_hv_dac_pkg::*;
#(
    parameter int HALF_PER = 3,
    parameter int LDAC_W   = 4,
    parameter int GAP      = 2
) (
    input  logic                     dtc_clk,
    input  logic                     rst_n,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [HV_DAC_CHIP_W-1:0] wr_chip,
    input  logic [HV_DAC_CH_W-1:0]   wr_ch,
    input  logic [HV_DAC_CODE_W-1:0] wr_data,
    input  logic                     wr_ldac,
    output logic                     busy,
    output logic                     done,
    output logic [HV_DAC_CHIPS-1:0]  hv_dac_sync_b,
    output logic                     hv_dac_sclk,
    output logic                     hv_dac_din,
    output logic                     hv_dac_load_b
);

    localparam int            WMAX      = (LDAC_W > GAP) ? LDAC_W : GAP;
    localparam int            WW        = $clog2(WMAX + 1);
    localparam logic [WW-1:0] LDAC_LAST = WW'(LDAC_W - 1);
    localparam logic [WW-1:0] GAP_LAST  = WW'(GAP - 1);

    hv_dac_state_e              state_q, state_d;
    logic [HV_DAC_FRAME_W-1:0]  shreg_q, shreg_d;
    logic [HV_DAC_CHIP_W-1:0]   chip_q, chip_d;
    logic                       ldac_q, ldac_d;
    logic                       sclk_q, sclk_d;
    logic [4:0]                 bit_q, bit_d;
    logic [WW-1:0]              wait_q, wait_d;
    logic                       done_q, done_d;
    logic                       armed_q, armed_d;

    logic in_frame;
    logic tick;
    logic accept;

    assign in_frame = (state_q == ST_SETUP) || (state_q == ST_SHIFT);
    assign wr_ready = armed_q && (state_q == ST_IDLE);
    assign accept   = wr_valid && wr_ready;

    fec_tick_gen #(
        .HALF_PER (HALF_PER)
    ) u_tick (
        .dtc_clk (dtc_clk),
        .rst_n   (rst_n),
        .clr     (!in_frame),
        .en      (in_frame),
        .tick    (tick)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        chip_d  = chip_q;
        ldac_d  = ldac_q;
        sclk_d  = sclk_q;
        bit_d   = bit_q;
        wait_d  = wait_q;
        done_d  = 1'b0;
        armed_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                sclk_d = 1'b1;
                bit_d  = '0;
                wait_d = '0;
                if (accept) begin
                    shreg_d = hv_dac_frame(wr_ch, wr_data);
                    chip_d  = wr_chip;
                    ldac_d  = wr_ldac;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    sclk_d  = 1'b0;
                    bit_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // 32nd half-period ends with sclk already high: leave it there
                if (tick) begin
                    if (bit_q == 5'd31) begin
                        wait_d  = '0;
                        state_d = ldac_q ? ST_LDAC : ST_GAP;
                    end else begin
                        sclk_d = ~sclk_q;
                        bit_d  = bit_q + 5'd1;
                        if (!sclk_q) begin
                            shreg_d = {shreg_q[HV_DAC_FRAME_W-2:0], 1'b0};
                        end
                    end
                end
            end
            ST_LDAC: begin
                if (wait_q == LDAC_LAST) begin
                    wait_d  = '0;
                    state_d = ST_GAP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (wait_q == GAP_LAST) begin
                    wait_d  = '0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge dtc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            chip_q  <= '0;
            ldac_q  <= 1'b0;
            sclk_q  <= 1'b1;
            bit_q   <= '0;
            wait_q  <= '0;
            done_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            chip_q  <= chip_d;
            ldac_q  <= ldac_d;
            sclk_q  <= sclk_d;
            bit_q   <= bit_d;
            wait_q  <= wait_d;
            done_q  <= done_d;
            armed_q <= armed_d;
        end
    end

    always_comb begin
        hv_dac_sync_b = '1;
        if (in_frame) begin
            hv_dac_sync_b[chip_q] = 1'b0;
        end
    end

    assign hv_dac_sclk   = sclk_q;
    assign hv_dac_din    = in_frame && shreg_q[HV_DAC_FRAME_W-1];
    assign hv_dac_load_b = (state_q != ST_LDAC);
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;

endmodule

// File: tb/tb_fec_hv_dac_spi.sv
// tb/tb_fec_hv_dac_spi.sv - directed self-checking bench for fec_hv_dac_spi
module tb_fec_hv_dac_spi;

    logic dtc_clk = 1'b0;
    always #5 dtc_clk = ~dtc_clk;

    logic rst_n;

    logic        wr_valid0, wr_ldac0, wr_ready0, busy0, done0, sclk0, din0, load_b0;
    logic [1:0]  wr_chip0;
    logic [2:0]  wr_ch0;
    logic [11:0] wr_data0;
    logic [3:0]  sync_b0;

    logic        wr_valid1, wr_ldac1, wr_ready1, busy1, done1, sclk1, din1, load_b1;
    logic [1:0]  wr_chip1;
    logic [2:0]  wr_ch1;
    logic [11:0] wr_data1;
    logic [3:0]  sync_b1;

    fec_hv_dac_spi dut0 (
        .dtc_clk       (dtc_clk),
        .rst_n         (rst_n),
        .wr_valid      (wr_valid0),
        .wr_ready      (wr_ready0),
        .wr_chip       (wr_chip0),
        .wr_ch         (wr_ch0),
        .wr_data       (wr_data0),
        .wr_ldac       (wr_ldac0),
        .busy          (busy0),
        .done          (done0),
        .hv_dac_sync_b (sync_b0),
        .hv_dac_sclk   (sclk0),
        .hv_dac_din    (din0),
        .hv_dac_load_b (load_b0)
    );

    fec_hv_dac_spi #(
        .HALF_PER (1)
    ) dut1 (
        .dtc_clk       (dtc_clk),
        .rst_n         (rst_n),
        .wr_valid      (wr_valid1),
        .wr_ready      (wr_ready1),
        .wr_chip       (wr_chip1),
        .wr_ch         (wr_ch1),
        .wr_data       (wr_data1),
        .wr_ldac       (wr_ldac1),
        .busy          (busy1),
        .done          (done1),
        .hv_dac_sync_b (sync_b1),
        .hv_dac_sclk   (sclk1),
        .hv_dac_din    (din1),
        .hv_dac_load_b (load_b1)
    );

    int checks = 0;
    int errors = 0;
    int lat;
    int n;

    logic [3:0]  prev_sync [2];
    logic        prev_sclk [2];
    logic        prev_din  [2];
    logic        prev_done [2];
    logic [15:0] word      [2];
    int          nfall     [2];
    int          low_cnt   [2];
    int          hi_run    [2];
    int          ldl_cnt   [2];
    logic [15:0] last_word [2];
    int          last_low  [2];
    int          last_nfall[2];
    int          last_hi   [2];
    logic        ld_at_rise[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int i);
        return (i == 0) ? wr_ready0 : wr_ready1;
    endfunction

    function automatic logic dn(input int i);
        return (i == 0) ? done0 : done1;
    endfunction

    task automatic monitor();
        logic [3:0] s;
        logic c, d, dd, lb;
        int nz;
        for (int i = 0; i < 2; i++) begin
            s  = (i == 0) ? sync_b0 : sync_b1;
            c  = (i == 0) ? sclk0   : sclk1;
            d  = (i == 0) ? din0    : din1;
            dd = (i == 0) ? done0   : done1;
            lb = (i == 0) ? load_b0 : load_b1;
            nz = 0;
            for (int b = 0; b < 4; b++) if (s[b] == 1'b0) nz++;
            chk("sync_at_most_one_low", 32'(nz <= 1), 32'd1);
            chk("load_b_vs_sync", 32'(!lb && (s != 4'hF)), 32'd0);
            chk("done_one_cycle", 32'(dd && prev_done[i]), 32'd0);
            if (s != 4'hF && prev_sync[i] != 4'hF && !(prev_sclk[i] == 1'b0 && c == 1'b1))
                chk("din_stable", 32'(d), 32'(prev_din[i]));
            if (prev_sync[i] == 4'hF && s != 4'hF) begin
                last_hi[i] = hi_run[i];
                word[i]    = '0;
                nfall[i]   = 0;
                low_cnt[i] = 0;
            end
            if (s != 4'hF && prev_sclk[i] && !c) begin
                word[i] = {word[i][14:0], d};
                nfall[i]++;
            end
            if (s != 4'hF) begin
                low_cnt[i]++;
                hi_run[i] = 0;
            end else begin
                hi_run[i]++;
            end
            if (prev_sync[i] != 4'hF && s == 4'hF) begin
                last_word[i]  = word[i];
                last_low[i]   = low_cnt[i];
                last_nfall[i] = nfall[i];
                ld_at_rise[i] = !lb;
                ldl_cnt[i]    = 0;
                chk("sclk_high_at_sync_rise", 32'(c), 32'd1);
            end
            if (!lb) ldl_cnt[i]++;
            prev_sync[i] = s;
            prev_sclk[i] = c;
            prev_din[i]  = d;
            prev_done[i] = dd;
        end
    endtask

    task automatic step();
        @(negedge dtc_clk);
        monitor();
    endtask

    task automatic send(input int i, input logic [1:0] chip, input logic [2:0] ch,
                        input logic [11:0] data, input logic ldac);
        int k;
        k = 0;
        if (i == 0) begin
            wr_chip0 = chip; wr_ch0 = ch; wr_data0 = data; wr_ldac0 = ldac; wr_valid0 = 1'b1;
        end else begin
            wr_chip1 = chip; wr_ch1 = ch; wr_data1 = data; wr_ldac1 = ldac; wr_valid1 = 1'b1;
        end
        while (rdy(i) !== 1'b1 && k < 200) begin
            step();
            k++;
        end
        chk("send_ready", 32'(rdy(i)), 32'd1);
        step();
        wr_valid0 = 1'b0;
        wr_valid1 = 1'b0;
    endtask

    task automatic wait_done(input int i, output int cyc);
        cyc = 0;
        while (dn(i) !== 1'b1 && cyc < 400) begin
            step();
            cyc++;
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_sync_b"}, 32'(sync_b0), 32'hF);
        chk({tag, "_sclk"},   32'(sclk0),   32'd1);
        chk({tag, "_din"},    32'(din0),    32'd0);
        chk({tag, "_load_b"}, 32'(load_b0), 32'd1);
        chk({tag, "_busy"},   32'(busy0),   32'd0);
        chk({tag, "_done"},   32'(done0),   32'd0);
        chk({tag, "_ready"},  32'(wr_ready0), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        wr_valid0 = 1'b0; wr_ldac0 = 1'b0; wr_chip0 = '0; wr_ch0 = '0; wr_data0 = '0;
        wr_valid1 = 1'b0; wr_ldac1 = 1'b0; wr_chip1 = '0; wr_ch1 = '0; wr_data1 = '0;
        for (int i = 0; i < 2; i++) begin
            prev_sync[i] = 4'hF; prev_sclk[i] = 1'b1; prev_din[i] = 1'b0; prev_done[i] = 1'b0;
            word[i] = '0; nfall[i] = 0; low_cnt[i] = 0; hi_run[i] = 0; ldl_cnt[i] = 0;
            last_word[i] = '0; last_low[i] = 0; last_nfall[i] = 0; last_hi[i] = 0;
            ld_at_rise[i] = 1'b0;
        end

        repeat (3) step();
        chk_idle("reset");
        chk("reset_ready1", 32'(wr_ready1), 32'd0);
        rst_n = 1'b1;
        step();
        chk("ready_after_reset", 32'(wr_ready0), 32'd1);

        // chip 0, ch 0, 0x033, no load
        send(0, 2'd0, 3'd0, 12'h033, 1'b0);
        chk("s1_sync_b", 32'(sync_b0), 32'hE);
        chk("s1_busy", 32'(busy0), 32'd1);
        chk("s1_ready_low", 32'(wr_ready0), 32'd0);
        wait_done(0, lat);
        chk("s1_latency", lat, 101);
        chk("s1_word", 32'(last_word[0]), 32'h0033);
        chk("s1_sync_low_cycles", last_low[0], 99);
        chk("s1_falls", last_nfall[0], 16);
        chk("s1_ready_in_done", 32'(wr_ready0), 32'd1);
        step();
        chk("s1_done_cleared", 32'(done0), 32'd0);

        // chip 3, ch 1, 0x0F0, with load pulse
        send(0, 2'd3, 3'd1, 12'h0F0, 1'b1);
        chk("s2_sync_b", 32'(sync_b0), 32'h7);
        wait_done(0, lat);
        chk("s2_latency", lat, 105);
        chk("s2_word", 32'(last_word[0]), 32'h10F0);
        chk("s2_sync_low_cycles", last_low[0], 99);
        chk("s2_load_at_sync_rise", 32'(ld_at_rise[0]), 32'd1);
        chk("s2_load_width", ldl_cnt[0], 4);
        step();

        // held wr_valid across a frame, second request taken right after done
        wr_chip0 = 2'd1; wr_ch0 = 3'd2; wr_data0 = 12'h5A5; wr_ldac0 = 1'b0; wr_valid0 = 1'b1;
        step();
        chk("s3a_sync_b", 32'(sync_b0), 32'hD);
        wait_done(0, lat);
        chk("s3a_latency", lat, 101);
        chk("s3a_word", 32'(last_word[0]), 32'h25A5);
        wr_chip0 = 2'd2; wr_ch0 = 3'd3; wr_data0 = 12'hABC;
        step();
        wr_valid0 = 1'b0;
        chk("s3b_accept_after_done", 32'(sync_b0), 32'hB);
        chk("s3_sync_high_gap", last_hi[0], 3);
        wait_done(0, lat);
        chk("s3b_latency", lat, 101);
        chk("s3b_word", 32'(last_word[0]), 32'h3ABC);
        step();

        // reset at the 8th falling sclk
        send(0, 2'd0, 3'd5, 12'h123, 1'b1);
        n = 0;
        while (nfall[0] != 8 && n < 300) begin
            step();
            n++;
        end
        chk("s4_reached_8th_fall", nfall[0], 8);
        rst_n = 1'b0;
        #1;
        chk_idle("s4_abort");
        repeat (2) step();
        chk("s4_load_quiet", 32'(load_b0), 32'd1);
        rst_n = 1'b1;
        step();
        chk("s4_ready_after_reset", 32'(wr_ready0), 32'd1);
        chk("s4_not_resumed", 32'(busy0), 32'd0);
        send(0, 2'd1, 3'd6, 12'hC3C, 1'b0);
        chk("s4_sync_b", 32'(sync_b0), 32'hD);
        wait_done(0, lat);
        chk("s4_latency", lat, 101);
        chk("s4_word", 32'(last_word[0]), 32'h6C3C);
        chk("s4_falls", last_nfall[0], 16);
        step();

        // HALF_PER = 1 instance
        send(1, 2'd1, 3'd7, 12'hFFF, 1'b0);
        chk("s5_sync_b", 32'(sync_b1), 32'hD);
        wait_done(1, lat);
        chk("s5_latency", lat, 35);
        chk("s5_word", 32'(last_word[1]), 32'h7FFF);
        chk("s5_sync_low_cycles", last_low[1], 33);
        chk("s5_falls", last_nfall[1], 16);
        step();
        send(1, 2'd0, 3'd0, 12'h001, 1'b1);
        chk("s6_sync_b", 32'(sync_b1), 32'hE);
        wait_done(1, lat);
        chk("s6_latency", lat, 39);
        chk("s6_word", 32'(last_word[1]), 32'h0001);
        chk("s6_load_width", ldl_cnt[1], 4);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fec_hv_dac_spi.md
FEC_HV_DAC_SPI -- requirements
Module: fec_hv_dac_spi

Interface
REQ-001 Parameter HALF_PER, default 3, dtc_clk cycles per HV_DAC_SCLK half-period (legal >= 1).
REQ-002 Parameter LDAC_W, default 4, width of the HV_DAC_LOAD_B low pulse in dtc_clk cycles (legal >= 1).
REQ-003 Parameter GAP, default 2, idle dtc_clk cycles after each frame before the next acceptance (legal >= 1).
REQ-004 dtc_clk  in  1  sole clock; all logic on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 wr_valid  in  1  DAC write request from the slow-command register block.
REQ-007 wr_ready  out  1  block accepts a request this cycle.
REQ-008 wr_chip  in  2  target DAC chip, selects one HV_DAC_SYNC_B bit.
REQ-009 wr_ch  in  3  DAC channel within the chip.
REQ-010 wr_data  in  12  DAC code.
REQ-011 wr_ldac  in  1  pulse HV_DAC_LOAD_B after this frame.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 done  out  1  one-cycle pulse at frame completion.
REQ-014 hv_dac_sync_b  out  4  per-chip frame select, active low.
REQ-015 hv_dac_sclk  out  1  serial clock, idles high.
REQ-016 hv_dac_din  out  1  serial data, MSB first.
REQ-017 hv_dac_load_b  out  1  shared DAC load strobe, active low.

Function
REQ-018 States: IDLE, SETUP, SHIFT, LDAC, GAP; a transfer is accepted only on a rising edge where wr_valid and wr_ready are both 1, and wr_ready SHALL equal 1 only in IDLE.
REQ-019 On acceptance: frame = {1'b0, wr_ch, wr_data} (16 bits), chip and ldac flag are latched; inputs are don't-care afterwards.
REQ-020 SETUP: hv_dac_sync_b[chip] = 0, sclk = 1, din = frame[15], for HALF_PER cycles, then SHIFT.
REQ-021 SHIFT: sclk toggles every HALF_PER cycles, giving 16 falling edges then 16 rising edges, ending high, for 32*HALF_PER cycles total; the DAC samples din on falling edges.
REQ-022 din advances to the next bit on each rising sclk edge; it SHALL be stable for HALF_PER cycles on both sides of each falling edge.
REQ-023 At SHIFT end, all hv_dac_sync_b bits return to 1; sync_b is low for exactly 33*HALF_PER cycles.
REQ-024 If the ldac flag is set, next state is LDAC (hv_dac_load_b = 0 for LDAC_W cycles); otherwise next state is GAP.
REQ-025 GAP: all serial outputs idle for GAP cycles, then IDLE; done = 1 in the first IDLE cycle only.
REQ-026 Latency from the accepting edge to done = 33*HALF_PER + GAP (+ LDAC_W if ldac) cycles; with defaults: 101 cycles, or 105 with ldac.
REQ-027 At most one hv_dac_sync_b bit SHALL be 0 at any time; hv_dac_load_b SHALL never be 0 while any sync_b bit is 0.
REQ-028 wr_valid while busy is ignored and not queued; the requester holds it until wr_ready.
REQ-029 Bit counter is 5 bits and the divider counter is clog2(HALF_PER+1) bits; neither SHALL wrap within a frame.
REQ-030 With HALF_PER = 1, sclk toggles every cycle and all rules above still hold.

Reset
REQ-031 rst_n low, at any time including mid-frame, immediately forces: state IDLE, hv_dac_sync_b = 4'hF, hv_dac_sclk = 1, hv_dac_din = 0, hv_dac_load_b = 1, busy = 0, done = 0, wr_ready = 0.
REQ-032 wr_ready rises on the first dtc_clk edge after rst_n deasserts; an aborted frame is never resumed.

Structure
REQ-033 Package fec_hv_dac_pkg holds the state enum, HV_DAC_FRAME_W = 16, HV_DAC_CHIPS = 4, HV_DAC_CODE_W = 12.
REQ-034 One sub-module, fec_tick_gen (parameterised HALF_PER strobe generator); everything else is inline.

Verification
REQ-035 Reset, then chip 0, ch 0, data 0x033, ldac 0 -> sync_b = 4'hE for 99 cycles; decoded word 0x0033; done at cycle 101.
REQ-036 chip 3, ch 1, data 0x0F0, ldac 1 -> sync_b = 4'h7; word 0x10F0; load_b low 4 cycles after sync rises; done at cycle 105.
REQ-037 Back-to-back held wr_valid, two requests -> second accepted exactly in the cycle after the first done; sync_b high for at least GAP cycles between frames.
REQ-038 rst_n low at the 8th falling sclk -> all outputs idle in the same cycle; a subsequent write transmits a complete correct frame.
REQ-039 HALF_PER = 1, data 0xFFF, ch 7 -> word 0x7FFF; sync_b low 33 cycles; a checker confirms din is stable around every falling edge.
REQ-040 Throughout all scenarios, assertions for REQ-027 and one-cycle done SHALL never fire.
